// File: rtl/lane_game_controller.sv
// lane_game_controller: falling-letter game controller over NUM_LANES columns.
//
// Owns the game state, score, lives, difficulty level, the shared fall-rate
// tick and the per-lane respawn pulses.
//
// Optional feature: define LANE_GAME_HIGH_SCORE_EN to build a high-score
// register. Otherwise high_score_o is tied to zero and no register is built.
//
// Ports:
//   clock_i        system clock
//   reset_n_i      asynchronous active-low reset
//   start_i        debounced start level; its rising edge is detected here
//   correct_i      per-lane "letter matched" pulse
//   game_over_i    per-lane "letter reached bottom" (miss) pulse
//   lane_reset_o   per-lane respawn/park request
//   fall_tick_o    one-cycle pulse; the columns advance one row
//   score_o        current score, saturating
//   lives_o        remaining lives
//   level_o        current difficulty level
//   state_o        00 IDLE, 01 PLAY, 10 OVER
//   high_score_o   best final score (only with LANE_GAME_HIGH_SCORE_EN)
module lane_game_controller #(
    parameter int NUM_LANES     = 3,
    parameter int SCORE_W       = 8,
    parameter int LIVES         = 3,
    parameter int LIVES_W       = 2,
    parameter int TICK_DIV      = 1666666,
    parameter int SPEEDUP_EVERY = 8,
    parameter int MAX_LEVEL     = 7
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic [NUM_LANES-1:0] correct_i,
    input  logic [NUM_LANES-1:0] game_over_i,
    output logic [NUM_LANES-1:0] lane_reset_o,
    output logic                 fall_tick_o,
    output logic [SCORE_W-1:0]   score_o,
    output logic [LIVES_W-1:0]   lives_o,
    output logic [2:0]           level_o,
    output logic [1:0]           state_o,
    output logic [SCORE_W-1:0]   high_score_o
);

    localparam int CW = $clog2(NUM_LANES + 1);
    localparam int TW = $clog2(TICK_DIV + 1);
    // Holds SPEEDUP_EVERY-1 plus one cycle's worth of points before the subtract.
    localparam int PW = $clog2(2 * SPEEDUP_EVERY);
    localparam int MW = (CW > LIVES_W) ? CW : LIVES_W;
    localparam logic [TW-1:0] TDIV = TW'(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [2:0]           level_q, level_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [PW-1:0]        pts_q, pts_d;
    logic                 start_q;
    logic                 fall_tick_q, fall_tick_d;
    logic [NUM_LANES-1:0] lane_reset_q, lane_reset_d;

    logic                 start_rise;
    logic [CW-1:0]        n_pts, n_miss;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;
    logic [MW-1:0]        miss_w, lives_w;
    logic [LIVES_W-1:0]   lives_nx;
    logic [PW-1:0]        pts_sum;
    logic                 pts_step, lvl_up, tick_wrap;

    assign start_rise = start_i & ~start_q;

    // A lane with both correct and miss set counts as correct only.
    always_comb begin
        n_pts  = '0;
        n_miss = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n_pts  = n_pts + CW'(correct_i[i]);
            n_miss = n_miss + CW'(game_over_i[i] & ~correct_i[i]);
        end
    end

    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(n_pts);
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    assign miss_w   = MW'(n_miss);
    assign lives_w  = MW'(lives_q);
    assign lives_nx = (miss_w >= lives_w) ? '0 : LIVES_W'(lives_w - miss_w);

    // The point counter keeps wrapping after the level saturates.
    assign pts_sum  = pts_q + PW'(n_pts);
    assign pts_step = pts_sum >= PW'(SPEEDUP_EVERY);
    assign lvl_up   = pts_step && (level_q < 3'(MAX_LEVEL));

    // The tick period halves with every level.
    assign tick_wrap = tick_q == ((TDIV >> level_q) - TW'(1));

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        lives_d      = lives_q;
        level_d      = level_q;
        tick_d       = tick_q;
        pts_d        = pts_q;
        fall_tick_d  = 1'b0;
        lane_reset_d = '1;
        if (state_q == PLAY) begin
            score_d = score_sat;
            lives_d = lives_nx;
            level_d = level_q + 3'(lvl_up);
            pts_d   = pts_step ? pts_sum - PW'(SPEEDUP_EVERY) : pts_sum;
            tick_d  = (lvl_up || tick_wrap) ? '0 : tick_q + TW'(1);
            if (lives_nx == '0) begin
                state_d = OVER;
            end else begin
                fall_tick_d  = tick_wrap;
                lane_reset_d = correct_i | game_over_i;
            end
        end else if (start_rise) begin
            state_d      = PLAY;
            score_d      = '0;
            lives_d      = LIVES_W'(LIVES);
            level_d      = '0;
            tick_d       = '0;
            pts_d        = '0;
            lane_reset_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            score_q      <= '0;
            lives_q      <= LIVES_W'(LIVES);
            level_q      <= '0;
            tick_q       <= '0;
            pts_q        <= '0;
            start_q      <= 1'b0;
            fall_tick_q  <= 1'b0;
            lane_reset_q <= '1;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            tick_q       <= tick_d;
            pts_q        <= pts_d;
            start_q      <= start_i;
            fall_tick_q  <= fall_tick_d;
            lane_reset_q <= lane_reset_d;
        end
    end

`ifdef LANE_GAME_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q, high_d;

    // Captured on the PLAY->OVER step, using the final score of that game.
    assign high_d = (state_q == PLAY && state_d == OVER && score_d > high_q) ? score_d : high_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            high_q <= '0;
        end else begin
            high_q <= high_d;
        end
    end

    assign high_score_o = high_q;
`else
    assign high_score_o = '0;
`endif

    assign lane_reset_o = lane_reset_q;
    assign fall_tick_o  = fall_tick_q;
    assign score_o      = score_q;
    assign lives_o      = lives_q;
    assign level_o      = level_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_lane_game_controller.sv
// tb_lane_game_controller: directed and random checks of lane_game_controller against a behavioural model.
module tb_lane_game_controller;

    localparam int NL      = 3;
    localparam int SW      = 4;
    localparam int LIVES   = 3;
    localparam int LW      = 2;
    localparam int TDIV    = 16;
    localparam int SPEEDUP = 4;
    localparam int MAXL    = 2;
    localparam int SMAX    = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [NL-1:0] correct, game_over;
    logic [NL-1:0] lane_reset;
    logic          fall_tick;
    logic [SW-1:0] score, high_score;
    logic [LW-1:0] lives;
    logic [2:0]    level;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    int m_state, m_score, m_lives, m_level, m_tcnt, m_pts, m_tick, m_lr, m_hs;
    bit m_prev;

    lane_game_controller #(
        .NUM_LANES(NL), .SCORE_W(SW), .LIVES(LIVES), .LIVES_W(LW),
        .TICK_DIV(TDIV), .SPEEDUP_EVERY(SPEEDUP), .MAX_LEVEL(MAXL)
    ) dut (
        .clock_i(clk), .reset_n_i(reset_n), .start_i(start),
        .correct_i(correct), .game_over_i(game_over),
        .lane_reset_o(lane_reset), .fall_tick_o(fall_tick),
        .score_o(score), .lives_o(lives), .level_o(level),
        .state_o(state), .high_score_o(high_score)
    );

    always #5 clk = ~clk;

    function automatic int exp_high();
`ifdef LANE_GAME_HIGH_SCORE_EN
        return m_hs;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset(input bit clear_high);
        m_state = 0; m_score = 0; m_lives = LIVES; m_level = 0;
        m_tcnt = 0; m_pts = 0; m_tick = 0; m_lr = 7; m_prev = 0;
        if (clear_high) m_hs = 0;
    endtask

    // Game rules applied to one clock edge, in plain integer arithmetic.
    task automatic model_step(input logic st, input logic [NL-1:0] c, input logic [NL-1:0] g);
        int nc, nm, per;
        bit rise, up, wrap;
        rise = st && !m_prev;
        m_prev = st;
        if (m_state != 1) begin
            m_tick = 0;
            m_lr = 7;
            if (rise) begin
                m_state = 1; m_score = 0; m_lives = LIVES; m_level = 0;
                m_tcnt = 0; m_pts = 0; m_lr = 0;
            end
        end else begin
            nc = $countones(c);
            nm = $countones(g & ~c);
            per = TDIV >> m_level;
            wrap = (m_tcnt == per - 1);
            m_score = (m_score + nc > SMAX) ? SMAX : m_score + nc;
            m_lives = (m_lives > nm) ? m_lives - nm : 0;
            m_pts += nc;
            up = 0;
            if (m_pts >= SPEEDUP) begin
                m_pts -= SPEEDUP;
                if (m_level < MAXL) begin
                    m_level++;
                    up = 1;
                end
            end
            m_tcnt = (up || wrap) ? 0 : m_tcnt + 1;
            if (m_lives == 0) begin
                m_state = 2; m_lr = 7; m_tick = 0;
                if (m_score > m_hs) m_hs = m_score;
            end else begin
                m_lr = int'(c | g);
                m_tick = int'(wrap);
            end
        end
    endtask

    task automatic step(input logic st, input logic [NL-1:0] c, input logic [NL-1:0] g);
        start = st; correct = c; game_over = g;
        @(posedge clk);
        model_step(st, c, g);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; start = 0; correct = 0; game_over = 0;
        #2 reset_n = 1'b0;
        #1;
        model_reset(1);
        checks += 7;
        if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        if (score !== 4'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
        if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", lives); end
        if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (fall_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0d expected 0", fall_tick); end
        if (lane_reset !== 3'b111) begin errors++; $display("FAIL reset_lane_reset: got %b expected 111", lane_reset); end
        if (high_score !== 4'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", high_score); end
        #10 reset_n = 1'b1;
        step(0, 0, 0);
    endtask

    task automatic test_start_tick();
        step(0, 0, 0);
        checks += 2;
        if (state !== 2'b00) begin errors++; $display("FAIL idle_state: got %0d expected 0", state); end
        if (lane_reset !== 3'b111) begin errors++; $display("FAIL idle_lane_reset: got %b expected 111", lane_reset); end
        step(1, 0, 0);
        checks += 4;
        if (state !== 2'b01) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
        if (lane_reset !== 3'b000) begin errors++; $display("FAIL start_lane_reset: got %b expected 000", lane_reset); end
        if (score !== 4'd0) begin errors++; $display("FAIL start_score: got %0d expected 0", score); end
        if (lives !== 2'd3) begin errors++; $display("FAIL start_lives: got %0d expected 3", lives); end
        for (int k = 1; k <= 34; k++) begin
            step(1, 0, 0);
            checks++;
            if (fall_tick !== ((k % 16) == 0)) begin
                errors++; $display("FAIL tick16 cycle %0d: got %0d expected %0d", k, fall_tick, (k % 16) == 0);
            end
        end
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL start_ignored_in_play: got %0d expected 1", state); end
    endtask

    task automatic test_scoring_level();
        step(0, 3'b101, 0);
        checks += 2;
        if (score !== 4'd2) begin errors++; $display("FAIL score_101: got %0d expected 2", score); end
        if (lane_reset !== 3'b101) begin errors++; $display("FAIL lane_reset_101: got %b expected 101", lane_reset); end
        step(0, 0, 0);
        checks++;
        if (lane_reset !== 3'b000) begin errors++; $display("FAIL lane_reset_clear: got %b expected 000", lane_reset); end
        step(0, 3'b011, 0);
        checks += 2;
        if (score !== 4'd4) begin errors++; $display("FAIL score_011: got %0d expected 4", score); end
        if (level !== 3'd1) begin errors++; $display("FAIL level_1: got %0d expected 1", level); end
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 0);
            checks++;
            if (fall_tick !== ((k % 8) == 0)) begin
                errors++; $display("FAIL tick8 cycle %0d: got %0d expected %0d", k, fall_tick, (k % 8) == 0);
            end
        end
    endtask

    task automatic test_collision_miss();
        step(0, 3'b001, 3'b001);
        checks += 2;
        if (lives !== 2'd3) begin errors++; $display("FAIL collide_lives: got %0d expected 3", lives); end
        if (score !== 4'd5) begin errors++; $display("FAIL collide_score: got %0d expected 5", score); end
        step(0, 0, 3'b110);
        checks += 2;
        if (lives !== 2'd1) begin errors++; $display("FAIL miss_lives: got %0d expected 1", lives); end
        if (lane_reset !== 3'b110) begin errors++; $display("FAIL miss_lane_reset: got %b expected 110", lane_reset); end
        step(0, 0, 0);
        checks++;
        if (lane_reset !== 3'b000) begin errors++; $display("FAIL miss_lane_clear: got %b expected 000", lane_reset); end
    endtask

    task automatic test_game_over();
        step(0, 0, 3'b001);
        checks += 4;
        if (state !== 2'b10) begin errors++; $display("FAIL over_state: got %0d expected 2", state); end
        if (lives !== 2'd0) begin errors++; $display("FAIL over_lives: got %0d expected 0", lives); end
        if (lane_reset !== 3'b111) begin errors++; $display("FAIL over_lane_reset: got %b expected 111", lane_reset); end
        if (score !== 4'd5) begin errors++; $display("FAIL over_score: got %0d expected 5", score); end
        for (int k = 0; k < 3; k++) begin
            step(0, 3'b111, 3'b000);
            checks += 4;
            if (score !== 4'd5) begin errors++; $display("FAIL over_frozen_score: got %0d expected 5", score); end
            if (state !== 2'b10) begin errors++; $display("FAIL over_hold_state: got %0d expected 2", state); end
            if (lane_reset !== 3'b111) begin errors++; $display("FAIL over_hold_lane: got %b expected 111", lane_reset); end
            if (fall_tick !== 1'b0) begin errors++; $display("FAIL over_tick: got %0d expected 0", fall_tick); end
        end
        step(1, 0, 0);
        checks += 4;
        if (state !== 2'b01) begin errors++; $display("FAIL restart_state: got %0d expected 1", state); end
        if (score !== 4'd0) begin errors++; $display("FAIL restart_score: got %0d expected 0", score); end
        if (lives !== 2'd3) begin errors++; $display("FAIL restart_lives: got %0d expected 3", lives); end
        if (level !== 3'd0) begin errors++; $display("FAIL restart_level: got %0d expected 0", level); end
        step(0, 0, 0);
    endtask

    task automatic test_saturation();
        int t0, t1;
        for (int k = 0; k < 4; k++) step(0, 3'b111, 0);
        checks += 2;
        if (score !== 4'd12) begin errors++; $display("FAIL sat_score12: got %0d expected 12", score); end
        if (level !== 3'd2) begin errors++; $display("FAIL sat_level_cap: got %0d expected 2", level); end
        t0 = -1; t1 = -1;
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0);
            if (fall_tick === 1'b1) begin
                if (t0 < 0) t0 = k;
                else if (t1 < 0) t1 = k;
            end
        end
        checks++;
        if (t0 < 0 || t1 - t0 != 4) begin errors++; $display("FAIL period4: got %0d expected 4", t1 - t0); end
        step(0, 3'b111, 0);
        step(0, 3'b001, 0);
        checks += 2;
        if (score !== 4'd15) begin errors++; $display("FAIL sat_score15: got %0d expected 15", score); end
        if (level !== 3'd2) begin errors++; $display("FAIL sat_level_hold: got %0d expected 2", level); end
        reset_n = 1'b0;
        #2;
        model_reset(1);
        checks += 5;
        if (state !== 2'b00) begin errors++; $display("FAIL midreset_state: got %0d expected 0", state); end
        if (score !== 4'd0) begin errors++; $display("FAIL midreset_score: got %0d expected 0", score); end
        if (lives !== 2'd3) begin errors++; $display("FAIL midreset_lives: got %0d expected 3", lives); end
        if (level !== 3'd0) begin errors++; $display("FAIL midreset_level: got %0d expected 0", level); end
        if (lane_reset !== 3'b111) begin errors++; $display("FAIL midreset_lane: got %b expected 111", lane_reset); end
        reset_n = 1'b1;
        step(0, 0, 0);
    endtask

    task automatic test_high_score();
        step(1, 0, 0);
        step(0, 3'b111, 0);
        step(0, 3'b111, 0);
        step(0, 3'b001, 0);
        step(0, 0, 3'b111);
        checks += 3;
        if (state !== 2'b10) begin errors++; $display("FAIL hs1_state: got %0d expected 2", state); end
        if (score !== 4'd7) begin errors++; $display("FAIL hs1_score: got %0d expected 7", score); end
        if (int'(high_score) !== exp_high()) begin errors++; $display("FAIL hs1_high: got %0d expected %0d", high_score, exp_high()); end
        step(1, 0, 0);
        checks++;
        if (int'(high_score) !== exp_high()) begin errors++; $display("FAIL hs_start_keep: got %0d expected %0d", high_score, exp_high()); end
        step(0, 3'b111, 0);
        step(0, 3'b011, 0);
        step(0, 0, 3'b111);
        checks += 2;
        if (score !== 4'd5) begin errors++; $display("FAIL hs2_score: got %0d expected 5", score); end
        if (int'(high_score) !== exp_high()) begin errors++; $display("FAIL hs2_high: got %0d expected %0d", high_score, exp_high()); end
        reset_n = 1'b0;
        #2;
        model_reset(1);
        checks++;
        if (high_score !== 4'd0) begin errors++; $display("FAIL hs_reset: got %0d expected 0", high_score); end
        reset_n = 1'b1;
        step(0, 0, 0);
    endtask

    task automatic test_random();
        logic st;
        logic [NL-1:0] c, g;
        st = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) st = ~st;
            c = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
            g = ($urandom_range(0, 9) == 0) ? NL'($urandom) : '0;
            step(st, c, g);
            checks += 8;
            if (int'(state) !== m_state) begin errors++; $display("FAIL rnd_state cyc %0d: got %0d expected %0d", k, state, m_state); end
            if (int'(score) !== m_score) begin errors++; $display("FAIL rnd_score cyc %0d: got %0d expected %0d", k, score, m_score); end
            if (int'(lives) !== m_lives) begin errors++; $display("FAIL rnd_lives cyc %0d: got %0d expected %0d", k, lives, m_lives); end
            if (int'(level) !== m_level) begin errors++; $display("FAIL rnd_level cyc %0d: got %0d expected %0d", k, level, m_level); end
            if (int'(fall_tick) !== m_tick) begin errors++; $display("FAIL rnd_tick cyc %0d: got %0d expected %0d", k, fall_tick, m_tick); end
            if (int'(lane_reset) !== m_lr) begin errors++; $display("FAIL rnd_lane_reset cyc %0d: got %0d expected %0d", k, lane_reset, m_lr); end
            if (int'(high_score) !== exp_high()) begin errors++; $display("FAIL rnd_high cyc %0d: got %0d expected %0d", k, high_score, exp_high()); end
            if ($isunknown({state, score, lives, level, fall_tick, lane_reset})) begin errors++; $display("FAIL rnd_unknown cyc %0d: got X expected known", k); end
        end
    endtask

    initial begin
        test_reset();
        test_start_tick();
        test_scoring_level();
        test_collision_miss();
        test_game_over();
        test_saturation();
        test_high_score();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
